// File: rtl/mac_poly_pkg.sv
// Shared types and constants for the mac_poly multiply-add controller.
// MAC_SIGNED_EN (optional define) switches the datapath to two's complement.
package mac_poly_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam logic MODE_SOP    = 1'b0;
  localparam logic MODE_HORNER = 1'b1;

  // Accumulator must hold one full product; at least one beat per packet.
  function automatic bit params_ok(input int data_w, input int max_terms, input int acc_w);
    return (data_w >= 1) && (max_terms >= 1) && (acc_w >= 2 * data_w);
  endfunction

endpackage

// File: rtl/mac_poly_if.sv
// Operand stream in, result stream out; slave side is the mac_poly_controller.
interface mac_poly_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic              mode;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [DATA_W-1:0] coef;
  logic [DATA_W-1:0] num_x;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  result;
  logic              overflow;
  logic              len_err;

  modport master (
    output mode, in_valid, in_last, coef, num_x, out_ready,
    input  in_ready, out_valid, result, overflow, len_err
  );

  modport slave (
    input  mode, in_valid, in_last, coef, num_x, out_ready,
    output in_ready, out_valid, result, overflow, len_err
  );
endinterface

// File: rtl/mac_poly_datapath.sv
// Accumulator, x latch and the single multiply-add with truncation/overflow.
// MAC_SIGNED_EN defined: operands and accumulator are two's complement.
module mac_poly_datapath
  import mac_poly_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              first_beat,
  input  logic              accum_beat,
  input  logic              horner,
  input  logic [DATA_W-1:0] coef,
  input  logic [DATA_W-1:0] num_x,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);
  // One spare bit above acc*x covers the following add without wrapping.
  localparam int FW = ACC_W + DATA_W + 1;

  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic              ovf_q, ovf_d;
  logic [FW-1:0]     coef_ext, num_x_ext, x_ext, acc_ext;
  logic [FW-1:0]     mul_a, mul_b, prod, full;
  logic              ovf_now;

`ifdef MAC_SIGNED_EN
  assign coef_ext  = {{(FW-DATA_W){coef[DATA_W-1]}}, coef};
  assign num_x_ext = {{(FW-DATA_W){num_x[DATA_W-1]}}, num_x};
  assign x_ext     = {{(FW-DATA_W){x_q[DATA_W-1]}}, x_q};
  assign acc_ext   = {{(FW-ACC_W){acc_q[ACC_W-1]}}, acc_q};
  assign ovf_now   = !((&full[FW-1:ACC_W-1]) || !(|full[FW-1:ACC_W-1]));
`else
  assign coef_ext  = FW'(coef);
  assign num_x_ext = FW'(num_x);
  assign x_ext     = FW'(x_q);
  assign acc_ext   = FW'(acc_q);
  assign ovf_now   = |full[FW-1:ACC_W];
`endif

  always_comb begin
    mul_a = (horner && !first_beat) ? acc_ext : coef_ext;
    mul_b = (horner && !first_beat) ? x_ext   : num_x_ext;
    prod  = mul_a * mul_b;
    if (horner) full = first_beat ? coef_ext : prod + coef_ext;
    else        full = first_beat ? prod     : acc_ext + prod;

    acc_d = acc_q;
    x_d   = x_q;
    ovf_d = ovf_q;
    if (clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (first_beat) begin
      acc_d = full[ACC_W-1:0];
      x_d   = num_x;
      ovf_d = ovf_now;
    end else if (accum_beat) begin
      acc_d = full[ACC_W-1:0];
      ovf_d = ovf_q | ovf_now;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      x_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      x_q   <= x_d;
      ovf_q <= ovf_d;
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;
endmodule

// File: rtl/mac_poly_controller.sv
// Packet controller: Horner polynomial or sum-of-products over a beat stream.
// MAC_SIGNED_EN (optional define) selects two's complement arithmetic.
module mac_poly_controller
  import mac_poly_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int MAX_TERMS = 8,
  parameter int ACC_W     = 20
) (
  input  logic     clk,
  input  logic     reset,
  mac_poly_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_TERMS + 2);

  if (!params_ok(DATA_W, MAX_TERMS, ACC_W)) begin : g_bad_params
    $error("mac_poly_controller: invalid DATA_W/MAX_TERMS/ACC_W");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             len_err_q, len_err_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             beat, first_beat, accum_beat, dp_clear, horner;
  logic [ACC_W-1:0] acc;
  logic             ovf;

  assign beat       = bus.in_valid && in_ready_q;
  assign first_beat = beat && (state_q == IDLE);
  assign accum_beat = beat && (state_q == ACCUM);
  assign dp_clear   = (state_q == DONE) && bus.out_ready;
  // Mode is taken live on the first beat, from the latch afterwards.
  assign horner     = first_beat ? (bus.mode == MODE_HORNER) : (mode_q == MODE_HORNER);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mode_d    = mode_q;
    len_err_d = len_err_q;
    case (state_q)
      IDLE: if (beat) begin
        mode_d    = bus.mode;
        count_d   = CNT_W'(1);
        len_err_d = 1'b0;
        state_d   = bus.in_last ? DONE : ACCUM;
      end
      ACCUM: if (beat) begin
        if (count_q != CNT_W'(MAX_TERMS + 1)) count_d = count_q + CNT_W'(1);
        if (count_q >= CNT_W'(MAX_TERMS))     len_err_d = 1'b1;
        if (bus.in_last)                      state_d = DONE;
      end
      DONE: if (bus.out_ready) begin
        state_d   = IDLE;
        count_d   = '0;
        len_err_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = (state_d == DONE);
    in_ready_d  = (state_d != DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      mode_q      <= MODE_SOP;
      len_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      len_err_q   <= len_err_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  mac_poly_datapath #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_datapath (
    .clk        (clk),
    .reset      (reset),
    .clear      (dp_clear),
    .first_beat (first_beat),
    .accum_beat (accum_beat),
    .horner     (horner),
    .coef       (bus.coef),
    .num_x      (bus.num_x),
    .acc        (acc),
    .ovf        (ovf)
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = out_valid_q ? acc : '0;
  assign bus.overflow  = out_valid_q & ovf;
  assign bus.len_err   = out_valid_q & len_err_q;
endmodule

// File: tb/tb_mac_poly_controller.sv
// Two controllers (20-bit/8 terms and 16-bit/2 terms) driven in lockstep and
// checked against an arithmetic reference model; honours MAC_SIGNED_EN.
module tb_mac_poly_controller;
`ifdef MAC_SIGNED_EN
  localparam bit SIGNED = 1'b1;
  localparam logic [63:0] SOP_WANT = 64'd61;
  localparam logic [63:0] OVF_WANT_A = 64'hFFFFF;
  localparam logic [63:0] OVF_WANT_B = 64'hFFFF;
`else
  localparam bit SIGNED = 1'b0;
  localparam logic [63:0] SOP_WANT = 64'd317;
  localparam logic [63:0] OVF_WANT_A = 64'd918015;
  localparam logic [63:0] OVF_WANT_B = 64'd511;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   passed = 0;
  int   failed = 0;
  logic [7:0] pc[$];
  logic [7:0] px[$];

  mac_poly_if #(.DATA_W(8), .ACC_W(20)) a_if ();
  mac_poly_if #(.DATA_W(8), .ACC_W(16)) b_if ();

  mac_poly_controller #(.DATA_W(8), .MAX_TERMS(8), .ACC_W(20)) dut_a (
    .clk(clk), .reset(reset), .bus(a_if)
  );
  mac_poly_controller #(.DATA_W(8), .MAX_TERMS(2), .ACC_W(16)) dut_b (
    .clk(clk), .reset(reset), .bus(b_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint opv(input logic [7:0] v);
    return SIGNED ? longint'($signed(v)) : longint'(v);
  endfunction

  // Reduce a value to what an ACC_W-bit register holds, read back as a number.
  function automatic longint wrap(input longint v, input int w);
    longint m;
    m = v & ((longint'(1) << w) - 1);
    if (SIGNED && m[w-1]) m = m - (longint'(1) << w);
    return m;
  endfunction

  function automatic void model(input bit m, input int acc_w, input int max_terms,
                                output logic [63:0] res, output bit ovf, output bit lerr);
    longint acc, full, x0, c;
    acc = 0;
    ovf = 1'b0;
    x0  = opv(px[0]);
    foreach (pc[i]) begin
      c = opv(pc[i]);
      if (m) full = (i == 0) ? c : acc * x0 + c;
      else   full = (i == 0) ? c * opv(px[i]) : acc + c * opv(px[i]);
      if (wrap(full, acc_w) != full) ovf = 1'b1;
      acc = wrap(full, acc_w);
    end
    res  = 64'(acc) & ((64'd1 << acc_w) - 64'd1);
    lerr = (pc.size() > max_terms);
  endfunction

  task automatic drive(input bit v, input bit m, input logic [7:0] c, input logic [7:0] x,
                       input bit last);
    a_if.in_valid = v; a_if.mode = m; a_if.coef = c; a_if.num_x = x; a_if.in_last = last;
    b_if.in_valid = v; b_if.mode = m; b_if.coef = c; b_if.num_x = x; b_if.in_last = last;
  endtask

  task automatic set_ready(input bit r);
    a_if.out_ready = r;
    b_if.out_ready = r;
  endtask

  task automatic check_idle(input string name);
    chk({name, ".a.out_valid"}, 64'(a_if.out_valid), 64'd0);
    chk({name, ".a.result"},    64'(a_if.result),    64'd0);
    chk({name, ".a.overflow"},  64'(a_if.overflow),  64'd0);
    chk({name, ".a.len_err"},   64'(a_if.len_err),   64'd0);
    chk({name, ".a.in_ready"},  64'(a_if.in_ready),  64'd1);
    chk({name, ".b.out_valid"}, 64'(b_if.out_valid), 64'd0);
    chk({name, ".b.result"},    64'(b_if.result),    64'd0);
    chk({name, ".b.in_ready"},  64'(b_if.in_ready),  64'd1);
  endtask

  // Sends the beats in pc/px, checks the result beat, holds it for `hold` cycles
  // with a refused beat on the input, then releases it.
  task automatic run_packet(input string name, input bit m, input bit gaps, input int hold,
                            input bit use_want, input logic [63:0] want_a,
                            input logic [63:0] want_b);
    logic [63:0] ra, rb;
    bit oa, ob, la, lb;
    int n;
    n = pc.size();
    model(m, 20, 8, ra, oa, la);
    model(m, 16, 2, rb, ob, lb);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'b1);
        @(negedge clk);
      end
      drive(1'b1, (i == 0) ? m : 1'($urandom), pc[i], px[i], i == n - 1);
      chk({name, ".a.in_ready"},  64'(a_if.in_ready),  64'd1);
      chk({name, ".a.early_valid"}, 64'(a_if.out_valid), 64'd0);
      chk({name, ".b.in_ready"},  64'(b_if.in_ready),  64'd1);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    chk({name, ".a.out_valid"}, 64'(a_if.out_valid), 64'd1);
    chk({name, ".a.result"},    64'(a_if.result),    ra);
    chk({name, ".a.overflow"},  64'(a_if.overflow),  64'(oa));
    chk({name, ".a.len_err"},   64'(a_if.len_err),   64'(la));
    chk({name, ".b.out_valid"}, 64'(b_if.out_valid), 64'd1);
    chk({name, ".b.result"},    64'(b_if.result),    rb);
    chk({name, ".b.overflow"},  64'(b_if.overflow),  64'(ob));
    chk({name, ".b.len_err"},   64'(b_if.len_err),   64'(lb));
    if (use_want) begin
      chk({name, ".a.const"}, 64'(a_if.result), want_a);
      chk({name, ".b.const"}, 64'(b_if.result), want_b);
    end
    $display("pkt %-12s mode=%0d beats=%0d a=0x%0h ovf=%0d len=%0d b=0x%0h ovf=%0d len=%0d",
             name, m, n, a_if.result, a_if.overflow, a_if.len_err,
             b_if.result, b_if.overflow, b_if.len_err);
    for (int k = 0; k < hold; k++) begin
      drive(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      chk({name, ".hold.in_ready"}, 64'(a_if.in_ready), 64'd0);
      @(negedge clk);
      chk({name, ".hold.valid"},  64'(a_if.out_valid), 64'd1);
      chk({name, ".hold.result"}, 64'(a_if.result),    ra);
      chk({name, ".hold.b"},      64'(b_if.result),    rb);
    end
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    set_ready(1'b1);
    @(negedge clk);
    set_ready(1'b0);
    check_idle({name, ".release"});
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    set_ready(1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_idle("reset");

    pc = '{8'd2, 8'd5, 8'd7};
    px = '{8'd3, 8'd99, 8'd200};
    run_packet("horner", 1'b1, 1'b0, 0, 1'b1, 64'd40, 64'd40);

    pc = '{8'd4, 8'd6, 8'd1};
    px = '{8'd5, 8'd7, 8'd255};
    run_packet("sop", 1'b0, 1'b0, 5, 1'b1, SOP_WANT, SOP_WANT);

    pc = '{8'd255, 8'd255, 8'd255};
    px = '{8'd255, 8'd1, 8'd2};
    run_packet("ovf_len", 1'b1, 1'b0, 1, 1'b1, OVF_WANT_A, OVF_WANT_B);

    pc = '{8'd200};
    px = '{8'd77};
    run_packet("sop_single", 1'b0, 1'b0, 0, 1'b0, 64'd0, 64'd0);

    // Abandon a packet by reset, then a single beat must not see its residue.
    drive(1'b1, 1'b1, 8'd200, 8'd17, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b1, 8'd250, 8'd3, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_mid");
    pc = '{8'd9};
    px = '{8'd99};
    run_packet("rst_then_9", 1'b1, 1'b0, 0, 1'b1, 64'd9, 64'd9);

`ifdef MAC_SIGNED_EN
    pc = '{8'hFD, 8'd2};
    px = '{8'd4, 8'd5};
    run_packet("signed_sop", 1'b0, 1'b0, 0, 1'b1, 64'hFFFFE, 64'hFFFE);
`endif

    for (int p = 0; p < 40; p++) begin
      int n;
      n = $urandom_range(1, 10);
      pc.delete();
      px.delete();
      for (int i = 0; i < n; i++) begin
        pc.push_back(8'($urandom));
        px.push_back(8'($urandom));
      end
      run_packet($sformatf("rand%0d", p), 1'($urandom), 1'b1, $urandom_range(0, 3),
                 1'b0, 64'd0, 64'd0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
